spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 152 +++++++++++++++
 tb/tb_spi_master_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one frame of DATA_W bits, MSB first, with selectable
// CPOL/CPHA. SCLK is a registered output derived from a clk-domain divider.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 10,
  parameter bit CPOL    = 1'b1,
  parameter bit CPHA    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_start,
  input  logic [DATA_W-1:0] spi_data_in,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic              CS_N,
  output logic [DATA_W-1:0] spi_data_out,
  output logic              spi_busy,
  output logic              spi_done
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] EDGE_LAST = 7'(2 * DATA_W - 1);

  state_t            state, state_next;
  logic [7:0]        div_cnt, div_next;
  logic [6:0]        edge_cnt, edge_next;
  logic [DATA_W-1:0] tx_sr, tx_next;
  logic [DATA_W-1:0] rx_sr, rx_next;
  logic [DATA_W-1:0] data_out_next;
  logic              sclk_next, mosi_next, cs_n_next, busy_next, done_next;
  logic              tick, leading, last_edge;

  assign tick      = (div_cnt == DIV_LAST);
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      SCLK         <= CPOL;
      CS_N         <= 1'b1;
      MOSI         <= 1'b0;
      spi_data_out <= '0;
      spi_busy     <= 1'b0;
      spi_done     <= 1'b0;
    end else begin
      state        <= state_next;
      div_cnt      <= div_next;
      edge_cnt     <= edge_next;
      tx_sr        <= tx_next;
      rx_sr        <= rx_next;
      SCLK         <= sclk_next;
      CS_N         <= cs_n_next;
      MOSI         <= mosi_next;
      spi_data_out <= data_out_next;
      spi_busy     <= busy_next;
      spi_done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    div_next      = div_cnt;
    edge_next     = edge_cnt;
    tx_next       = tx_sr;
    rx_next       = rx_sr;
    sclk_next     = SCLK;
    cs_n_next     = CS_N;
    mosi_next     = MOSI;
    data_out_next = spi_data_out;
    busy_next     = spi_busy;
    done_next     = 1'b0;

    case (state)
      IDLE: begin
        sclk_next = CPOL;
        cs_n_next = 1'b1;
        mosi_next = 1'b0;
        busy_next = 1'b0;
        if (spi_start) begin
          tx_next    = spi_data_in;
          rx_next    = '0;
          div_next   = '0;
          edge_next  = '0;
          busy_next  = 1'b1;
          cs_n_next  = 1'b0;
          // With CPHA=0 the first bit must already be valid at the first (sampling) edge.
          mosi_next  = CPHA ? 1'b0 : spi_data_in[DATA_W-1];
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          div_next   = '0;
          state_next = SHIFT;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (tick) begin
          div_next  = '0;
          sclk_next = ~SCLK;
          edge_next = edge_cnt + 7'd1;
          if (leading != CPHA)
            rx_next = {rx_sr[DATA_W-2:0], MISO};
          if (CPHA && leading) begin
            mosi_next = tx_sr[DATA_W-1];
            tx_next   = {tx_sr[DATA_W-2:0], 1'b0};
          end else if (!CPHA && !leading && !last_edge) begin
            mosi_next = tx_sr[DATA_W-2];
            tx_next   = {tx_sr[DATA_W-2:0], 1'b0};
          end
          if (last_edge)
            state_next = HOLD;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end

      HOLD: begin
        if (tick) begin
          div_next   = '0;
          cs_n_next  = 1'b1;
          state_next = DONE;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end

      DONE: begin
        data_out_next = rx_sr;
        done_next     = 1'b1;
        busy_next     = 1'b0;
        mosi_next     = 1'b0;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three parameterisations (loopback, constant
// MISO, 16-bit slave model) plus ignore, mid-frame reset and back-to-back cases.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: DATA_W=8, CLK_DIV=2, CPOL=1, CPHA=1, MISO looped back from MOSI
  logic       start_a, mosi_a, sclk_a, csn_a, busy_a, done_a;
  logic [7:0] din_a, dout_a;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) dut_a (
    .clk(clk), .reset(reset), .spi_start(start_a), .spi_data_in(din_a), .MISO(mosi_a),
    .MOSI(mosi_a), .SCLK(sclk_a), .CS_N(csn_a), .spi_data_out(dout_a),
    .spi_busy(busy_a), .spi_done(done_a)
  );

  // Instance B: DATA_W=8, CLK_DIV=4, CPOL=0, CPHA=0, MISO tied high
  logic       start_b, mosi_b, sclk_b, csn_b, busy_b, done_b;
  logic [7:0] din_b, dout_b, cap_b;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) dut_b (
    .clk(clk), .reset(reset), .spi_start(start_b), .spi_data_in(din_b), .MISO(1'b1),
    .MOSI(mosi_b), .SCLK(sclk_b), .CS_N(csn_b), .spi_data_out(dout_b),
    .spi_busy(busy_b), .spi_done(done_b)
  );

  always @(posedge sclk_b) cap_b <= {cap_b[6:0], mosi_b};

  // Instance C: DATA_W=16, CLK_DIV=2, CPOL=0, CPHA=1, slave shifts 0x1234 out on rising SCLK
  localparam logic [15:0] SLAVE_WORD = 16'h1234;
  logic        start_c, mosi_c, sclk_c, csn_c, busy_c, done_c, miso_c;
  logic [15:0] din_c, dout_c;
  logic [4:0]  slave_idx;

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b1)) dut_c (
    .clk(clk), .reset(reset), .spi_start(start_c), .spi_data_in(din_c), .MISO(miso_c),
    .MOSI(mosi_c), .SCLK(sclk_c), .CS_N(csn_c), .spi_data_out(dout_c),
    .spi_busy(busy_c), .spi_done(done_c)
  );

  always @(posedge sclk_c or posedge csn_c)
    if (csn_c) slave_idx <= 5'd0;
    else       slave_idx <= slave_idx + 5'd1;

  always_comb begin
    miso_c = 1'b0;
    if (slave_idx >= 5'd1 && slave_idx <= 5'd16)
      miso_c = SLAVE_WORD[4'(5'd16 - slave_idx)];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic s, input logic [15:0] d);
    case (sel)
      0:       begin start_a = s; din_a = d[7:0]; end
      1:       begin start_b = s; din_b = d[7:0]; end
      default: begin start_c = s; din_c = d;      end
    endcase
  endtask

  function automatic logic [2:0] mon(input int sel);
    case (sel)
      0:       return {busy_a, done_a, sclk_a};
      1:       return {busy_b, done_b, sclk_b};
      default: return {busy_c, done_c, sclk_c};
    endcase
  endfunction

  // Walks a fixed number of negedges counting busy cycles, SCLK toggles and done pulses;
  // optionally re-pulses spi_start with other data at cycle poke_at.
  task automatic measure(input int sel, input int cycles, input int poke_at,
                         input logic [15:0] poke_data, output int busy_n,
                         output int toggles, output int done_n, output int done_ok);
    logic [2:0] m, prev;
    busy_n = 0; toggles = 0; done_n = 0; done_ok = 0;
    prev = mon(sel);
    for (int i = 0; i < cycles; i++) begin
      if (i == poke_at)          apply_stimulus(sel, 1'b1, poke_data);
      else if (i == poke_at + 1) apply_stimulus(sel, 1'b0, poke_data);
      m = mon(sel);
      if (m[2]) busy_n++;
      if (m[1]) begin
        done_n++;
        if (prev[2] && !m[2]) done_ok++;
      end
      if (m[0] !== prev[0]) toggles++;
      prev = m;
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input int sel, input logic [15:0] d);
    apply_stimulus(sel, 1'b1, d);
    @(negedge clk);
    apply_stimulus(sel, 1'b0, d);
  endtask

  initial begin
    int busy_n, toggles, done_n, done_ok, gap, frame_busy;
    logic prev_sclk;

    reset = 1'b1;
    apply_stimulus(0, 1'b0, 16'h0);
    apply_stimulus(1, 1'b0, 16'h0);
    apply_stimulus(2, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    check_output("rst_sclk_a", 32'(sclk_a), 32'd1);
    check_output("rst_csn_a",  32'(csn_a),  32'd1);
    check_output("rst_mosi_a", 32'(mosi_a), 32'd0);
    check_output("rst_busy_a", 32'(busy_a), 32'd0);
    check_output("rst_done_a", 32'(done_a), 32'd0);
    check_output("rst_dout_a", 32'(dout_a), 32'd0);
    check_output("rst_sclk_b", 32'(sclk_b), 32'd0);
    check_output("rst_sclk_c", 32'(sclk_c), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Loopback frame on A
    start_frame(0, 16'h00A5);
    measure(0, 60, -10, 16'h0, busy_n, toggles, done_n, done_ok);
    check_output("a_busy_cycles", 32'(busy_n),  32'd37);
    check_output("a_toggles",     32'(toggles), 32'd16);
    check_output("a_done_pulses", 32'(done_n),  32'd1);
    check_output("a_done_at_fall", 32'(done_ok), 32'd1);
    check_output("a_dout",        32'(dout_a),  32'h00A5);
    check_output("a_sclk_idle",   32'(sclk_a),  32'd1);
    check_output("a_csn_idle",    32'(csn_a),   32'd1);

    // Mode 0 frame on B, MISO constant 1
    start_frame(1, 16'h003C);
    measure(1, 100, -10, 16'h0, busy_n, toggles, done_n, done_ok);
    check_output("b_busy_cycles", 32'(busy_n),  32'd73);
    check_output("b_toggles",     32'(toggles), 32'd16);
    check_output("b_done_pulses", 32'(done_n),  32'd1);
    check_output("b_mosi_bits",   32'(cap_b),   32'h003C);
    check_output("b_dout",        32'(dout_b),  32'h00FF);
    check_output("b_sclk_idle",   32'(sclk_b),  32'd0);

    // 16-bit frame on C against the slave model
    start_frame(2, 16'hBEEF);
    measure(2, 90, -10, 16'h0, busy_n, toggles, done_n, done_ok);
    check_output("c_busy_cycles", 32'(busy_n),  32'd69);
    check_output("c_toggles",     32'(toggles), 32'd32);
    check_output("c_done_pulses", 32'(done_n),  32'd1);
    check_output("c_dout",        32'(dout_c),  32'h1234);

    // Start re-pulsed with new data mid-frame must be ignored
    start_frame(0, 16'h005A);
    measure(0, 60, 4, 16'h00FF, busy_n, toggles, done_n, done_ok);
    check_output("ign_busy_cycles", 32'(busy_n), 32'd37);
    check_output("ign_done_pulses", 32'(done_n), 32'd1);
    check_output("ign_dout",        32'(dout_a), 32'h005A);
    check_output("ign_still_idle",  32'(busy_a), 32'd0);

    // Reset after the 5th SCLK toggle aborts the frame; reset also beats spi_start
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("rst2_dout_clear", 32'(dout_a), 32'd0);
    start_frame(0, 16'h00C3);
    toggles = 0;
    prev_sclk = sclk_a;
    for (int i = 0; i < 100 && toggles < 5; i++) begin
      @(negedge clk);
      if (sclk_a !== prev_sclk) toggles++;
      prev_sclk = sclk_a;
    end
    check_output("abort_reached_toggle5", 32'(toggles), 32'd5);
    reset = 1'b1;
    apply_stimulus(0, 1'b1, 16'h00C3);
    @(negedge clk);
    check_output("abort_csn",  32'(csn_a),  32'd1);
    check_output("abort_sclk", 32'(sclk_a), 32'd1);
    check_output("abort_busy", 32'(busy_a), 32'd0);
    check_output("abort_done", 32'(done_a), 32'd0);
    check_output("abort_dout", 32'(dout_a), 32'd0);
    reset = 1'b0;
    apply_stimulus(0, 1'b0, 16'h00C3);
    measure(0, 50, -10, 16'h0, busy_n, toggles, done_n, done_ok);
    check_output("abort_no_done", 32'(done_n), 32'd0);
    check_output("abort_no_busy", 32'(busy_n), 32'd0);

    // spi_start held high: back-to-back frames separated by one idle cycle
    apply_stimulus(0, 1'b1, 16'h0081);
    done_n = 0;
    gap = 0;
    frame_busy = 0;
    for (int i = 0; i < 200 && done_n < 2; i++) begin
      @(negedge clk);
      if (done_a) begin
        done_n++;
        check_output($sformatf("b2b_dout_%0d", done_n), 32'(dout_a), 32'h0081);
        if (done_n == 2) apply_stimulus(0, 1'b0, 16'h0081);
      end
      if (done_n == 1 && !busy_a) gap++;
      if (done_n == 1 && busy_a) frame_busy++;
    end
    check_output("b2b_frames",     32'(done_n),     32'd2);
    check_output("b2b_idle_gap",   32'(gap),        32'd1);
    check_output("b2b_frame_busy", 32'(frame_busy), 32'd37);
    @(negedge clk);
    check_output("b2b_stopped", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
